// File: rtl/hier_pipe_chain.sv
// Elastic chain of DEPTH masked-AND stages feeding an inverting output register.
// Optional out_parity port/logic enabled by defining HIER_PIPE_PARITY_EN.
module hier_pipe_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DEPTH*WIDTH-1:0]     in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
`ifdef HIER_PIPE_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH+2)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 2);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] stage_ld_c;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
`ifdef HIER_PIPE_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic out_ld_c;
    logic accept_c;
    logic emit_c;

    // A stage may load if it, or any stage downstream of it, has a bubble,
    // or if the output register is draining this cycle.
    always_comb begin
        logic ld;
        out_ld_c   = ~out_valid_q | out_ready;
        stage_ld_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ld = out_ld_c;
            for (int j = 0; j < DEPTH; j++) begin
                if (j >= k && !valid_q[j]) begin
                    ld = 1'b1;
                end
            end
            stage_ld_c[k] = ld;
        end
    end

    assign in_ready = stage_ld_c[0] & ~rst;
    assign accept_c = in_valid & in_ready;
    assign emit_c   = out_valid_q & out_ready;

    // Stage advance: masks are applied at the moment each stage loads.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (stage_ld_c[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = in_data & in_mask[0 +: WIDTH];
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (stage_ld_c[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1] & in_mask[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Output register and occupancy counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef HIER_PIPE_PARITY_EN
        parity_d    = parity_q;
`endif
        if (out_ld_c) begin
            out_valid_d = valid_q[DEPTH-1];
            if (valid_q[DEPTH-1]) begin
                out_data_d = ~data_q[DEPTH-1];
`ifdef HIER_PIPE_PARITY_EN
                parity_d   = ^(~data_q[DEPTH-1]);
`endif
            end
        end

        count_d = count_q;
        case ({accept_c, emit_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
`ifdef HIER_PIPE_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
`ifdef HIER_PIPE_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Stage payloads are qualified by valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;
`ifdef HIER_PIPE_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_hier_pipe_chain.sv
// Self-checking bench for hier_pipe_chain: vector table, scoreboard and corner sequences.
module tb_hier_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic [15:0] in_mask;
    logic [1:0]  count;
`ifdef HIER_PIPE_PARITY_EN
    logic        out_parity, out_parity2;
`endif

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [3:0]  in_data2, in_mask2, out_data2;
    logic [1:0]  count2;

    hier_pipe_chain #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
`ifdef HIER_PIPE_PARITY_EN
        .out_parity(out_parity),
`endif
        .count(count)
    );

    hier_pipe_chain #(.WIDTH(4), .DEPTH(1)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_mask(in_mask2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2),
`ifdef HIER_PIPE_PARITY_EN
        .out_parity(out_parity2),
`endif
        .count(count2)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] m0;
        logic [7:0] m1;
        logic [7:0] exp;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         popped = 0;
    int         accepted = 0;
    logic [7:0] sb_q[$];
    bit         auto_exp = 1'b1;
    logic [7:0] man_exp = 8'h00;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then step past the rising edge.
    task automatic cycle();
        logic [7:0] e;
        @(negedge clk);
        if (stall_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(stall_data));
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(auto_exp ? ~(in_data & in_mask[7:0] & in_mask[15:8]) : man_exp);
            accepted++;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got output %0h with nothing expected", out_data);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(out_data), 64'(e));
`ifdef HIER_PIPE_PARITY_EN
                check("out_parity", 64'(out_parity), 64'(^e));
`endif
                popped++;
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        in_valid = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            cycle();
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[8];
        int   idx;
        int   base_acc;
        int   base_pop;
        int   c;
        bit   acc;

        tbl[0] = '{8'hFF, 8'hF0, 8'h3C, 8'hCF};
        tbl[1] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        tbl[3] = '{8'hA5, 8'h0F, 8'hFF, 8'hFA};
        tbl[4] = '{8'h5A, 8'hF0, 8'h0F, 8'hFF};
        tbl[5] = '{8'hC3, 8'hFF, 8'h81, 8'h7E};
        tbl[6] = '{8'h3C, 8'h3C, 8'hF0, 8'hCF};
        tbl[7] = '{8'h96, 8'hF6, 8'h7F, 8'hE9};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_mask2 = '0; out_ready2 = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_count2", 64'(count2), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Basic latency: accepted in cycle 0, visible in cycle 3
        in_mask = {8'h3C, 8'hF0}; in_data = 8'hFF; in_valid = 1'b1;
        auto_exp = 1'b0; man_exp = 8'hCF;
        cycle();
        in_valid = 1'b0;
        check("basic_lat1", 64'(out_valid), 64'd0);
        cycle();
        check("basic_lat2", 64'(out_valid), 64'd0);
        cycle();
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_data", 64'(out_data), 64'hCF);
`ifdef HIER_PIPE_PARITY_EN
        check("basic_parity", 64'(out_parity), 64'd0);
`endif
        drain(10);

        // Vector table, one word at a time with its own masks
        for (int i = 0; i < 8; i++) begin
            in_data  = tbl[i].d;
            in_mask  = {tbl[i].m1, tbl[i].m0};
            man_exp  = tbl[i].exp;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            drain(10);
        end

        // Mask sampled when the stage loads, not at acceptance
        man_exp = 8'hF0;
        in_mask = {8'h00, 8'h0F}; in_data = 8'hFF; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_mask  = {8'hFF, 8'h0F};
        drain(10);
        auto_exp = 1'b1;

        // Fill to capacity with the output stalled
        in_mask = 16'hFFFF; out_ready = 1'b0; in_valid = 1'b1; idx = 0;
        #1;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'(idx + 1);
            acc = in_ready;
            cycle();
            if (acc) idx++;
        end
        check("fill_accepted", 64'(idx), 64'd3);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        check("fill_count", 64'(count), 64'd3);
        check("fill_head", 64'(out_data), 64'hFE);

        // Full with output draining: one in, one out per cycle
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            in_data = 8'(idx + 1);
            check("simul_ready", 64'(in_ready), 64'd1);
            cycle();
            idx++;
            check("simul_count", 64'(count), 64'd3);
        end
        drain(20);
        check("simul_final_count", 64'(count), 64'd0);

        // Reset with two words in flight
        in_data = 8'hAA; in_valid = 1'b1;
        cycle();
        in_data = 8'hBB;
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        stall_prev = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(count), 64'd0);
        #1;
        check("midrst_ready_after", 64'(in_ready), 64'd1);
        for (int k = 0; k < 5; k++) cycle();
        check("midrst_quiet", 64'(out_valid), 64'd0);

        // Backpressure: out_ready toggles every cycle over 20 words
        in_mask  = 16'($urandom);
        base_acc = accepted;
        base_pop = popped;
        in_data  = 8'($urandom);
        in_valid = 1'b1;
        c = 0;
        while ((accepted - base_acc) < 20 && c < 400) begin
            out_ready = c[0];
            idx = accepted;
            cycle();
            if (accepted != idx) in_data = 8'($urandom);
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_accepted", 64'(accepted - base_acc), 64'd20);
        drain(40);
        check("bp_popped", 64'(popped - base_pop), 64'd20);
        check("bp_count", 64'(count), 64'd0);

        // DEPTH=1, WIDTH=4 instance
        in_mask2 = 4'hA; in_data2 = 4'hF; in_valid2 = 1'b1;
        cycle();
        in_valid2 = 1'b0;
        check("p_lat1", 64'(out_valid2), 64'd0);
        cycle();
        check("p_valid", 64'(out_valid2), 64'd1);
        check("p_data", 64'(out_data2), 64'h5);
        out_ready2 = 1'b0; in_data2 = 4'h3; in_valid2 = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        check("p_count_full", 64'(count2), 64'd2);
        check("p_in_ready_full", 64'(in_ready2), 64'd0);
        check("p_hold", 64'(out_data2), 64'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hier_pipe_chain.md
HIER_PIPE_CHAIN -- requirements
Module: hier_pipe_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of AND stages (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the upstream word.
REQ-008 The block SHALL have port in_mask, input, DEPTH*WIDTH bits: stage k uses operand slice [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the result word, registered.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH+2) bits: words held in the block.
REQ-013 The block SHALL have port out_parity, output, 1 bit, present only when the Configuration macro is defined.

Function
REQ-014 Each stage k SHALL be one valid bit plus a WIDTH-bit data register; stage 0 loads in_data & in_mask slice 0, and stage k>0 loads stage(k-1) data & in_mask slice k.
REQ-015 The output register SHALL load the bitwise inverse of the last stage's data into out_data.
REQ-016 A stage or the output register SHALL load in a cycle when it is empty or its contents leave that cycle (bubble-collapsing); otherwise it SHALL hold its contents.
REQ-017 in_ready SHALL equal the stage-0 load condition, evaluated combinationally in the same cycle.
REQ-018 A transfer SHALL occur on valid&ready at each interface; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 With no stalls, latency from input acceptance to out_valid SHALL be DEPTH+1 cycles, with throughput of one word per cycle.
REQ-020 Capacity SHALL be DEPTH+1 words; at full with out_ready=0, in_ready SHALL be 0.
REQ-021 At full with out_ready=1, an input SHALL be accepted in the same cycle and count SHALL stay DEPTH+1.
REQ-022 count SHALL increment on accept-only, decrement on emit-only, and hold on both or neither; it SHALL never wrap.
REQ-023 in_mask slices SHALL be sampled at the cycle the corresponding stage loads, not at input acceptance.

Reset
REQ-024 While rst=1 at a clock edge, all valid bits SHALL clear, count=0, out_valid=0, and in_ready SHALL be 1 in the following cycle.
REQ-025 Reset SHALL clear out_data=0 (and out_parity=0); stage data registers need not be reset.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight words with no output transfer, and in_ready SHALL be 0 while rst=1.

Configuration
REQ-027 When HIER_PIPE_PARITY_EN is defined, out_parity SHALL be registered with out_data as the XOR-reduction of the loaded out_data value and held with it.
REQ-028 When HIER_PIPE_PARITY_EN is undefined, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Basic: WIDTH=8, DEPTH=2, mask slice 0=0xF0, slice 1=0x3C, in_data=0xFF accepted at cycle 0 -> out_valid=1 at cycle 3, out_data=0xCF, out_parity=0.
REQ-030 Fill: out_ready=0, in_valid=1 with data 0x01, 0x02, 0x03, 0x04 -> first three are accepted, then in_ready=0 and count=3; the fourth is held.
REQ-031 Simultaneous: full, out_ready=1, in_valid=1 -> one emit and one accept per cycle, count stays 3, and outputs appear in order.
REQ-032 Reset mid-operation: two words in flight, rst=1 for one cycle -> next cycle out_valid=0, count=0; in_ready=1 after rst deasserts.
REQ-033 Parameters: DEPTH=1, WIDTH=4, mask=0xA, in_data=0xF -> out_data=0x5 after 2 cycles, and the count width is 2 bits.
REQ-034 Backpressure: out_ready toggling 1/0 every cycle over a 20-word stream -> no loss or duplication, and out_data is stable during stalls.
